// File: rtl/target_cmd_seq_if.sv
// target_cmd_seq_if: register-bus link between the command sequencer and the bridge command block
interface target_cmd_seq_if;
   logic        o_cpu_req;
   logic [31:0] o_cpu_addr;
   logic [31:0] o_cpu_wdata;
   logic [3:0]  o_cpu_wstrb;
   logic        i_cpu_ack_pulse;
   logic [31:0] i_cpu_rdata;
   modport master (output o_cpu_req, o_cpu_addr, o_cpu_wdata, o_cpu_wstrb, input i_cpu_ack_pulse, i_cpu_rdata);
   modport slave (input o_cpu_req, o_cpu_addr, o_cpu_wdata, o_cpu_wstrb, output i_cpu_ack_pulse, i_cpu_rdata);
endinterface

// File: rtl/target_cmd_seq.sv
// target_cmd_seq: writes params and a command to the target, polls for completion, reads back the response
module target_cmd_seq #(
   parameter int GAP_CYCLES = 8,
   parameter int POLL_LIMIT = 65535
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_start,
   input  logic [15:0]      cmd_code,
   input  logic [127:0]     cmd_param,
   output logic             cmd_busy,
   output logic             cmd_done,
   output logic [15:0]      cmd_result,
   output logic [127:0]     cmd_resp,
   output logic             cmd_timeout,
   target_cmd_seq_if.master bus
);
   typedef enum logic [2:0] {IDLE, WPARAM, WCMD, POLL, RRESP, DONE} state_t;
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);
   state_t state, state_nxt;
   logic [15:0] code_r, gap_cnt, poll_cnt;
   logic [127:0] param_r;
   logic [1:0] idx;
   logic ack, status_ok, poll_last, issue, tx_write;
   logic [7:0] tx_addr;
   logic [31:0] tx_wdata;
   // an ack only counts while our own request is up; stale pulses are dropped
   assign ack = bus.o_cpu_req && bus.i_cpu_ack_pulse;
   assign status_ok = bus.i_cpu_rdata[31:16] == 16'h6F6B;
   assign poll_last = poll_cnt == POLL_LAST;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = cmd_start ? WPARAM : IDLE;
         WPARAM:  state_nxt = (ack && idx == 2'd3) ? WCMD : WPARAM;
         WCMD:    state_nxt = ack ? POLL : WCMD;
         POLL:    state_nxt = !ack ? POLL : status_ok ? RRESP : poll_last ? DONE : POLL;
         RRESP:   state_nxt = (ack && idx == 2'd3) ? DONE : RRESP;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      cmd_busy = state != IDLE && state != DONE;
      cmd_done = state == DONE;
      issue = cmd_busy && !bus.o_cpu_req && gap_cnt == GAP_LAST;
      tx_write = state == WPARAM || state == WCMD;
      tx_addr = state == WPARAM ? {4'h2, idx, 2'b00} : state == RRESP ? {4'h4, idx, 2'b00} : 8'h00;
      tx_wdata = state == WPARAM ? param_r[32*idx +: 32] : state == WCMD ? {16'h636D, code_r} : 32'h0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bus.o_cpu_req <= 1'b0;
         bus.o_cpu_addr <= '0;
         bus.o_cpu_wdata <= '0;
         bus.o_cpu_wstrb <= '0;
         cmd_result <= '0;
         cmd_resp <= '0;
         cmd_timeout <= 1'b0;
         code_r <= '0;
         param_r <= '0;
         gap_cnt <= '0;
         poll_cnt <= '0;
         idx <= '0;
      end else begin
         if (state == IDLE && cmd_start) begin
            code_r <= cmd_code;
            param_r <= cmd_param;
            cmd_timeout <= 1'b0;
            poll_cnt <= '0;
            idx <= '0;
         end
         // gap counter saturates, so an idle link is immediately ready for the next request
         if (issue) begin
            bus.o_cpu_req <= 1'b1;
            bus.o_cpu_addr <= {24'h0, tx_addr};
            bus.o_cpu_wdata <= tx_wdata;
            bus.o_cpu_wstrb <= {4{tx_write}};
         end else if (ack) begin
            bus.o_cpu_req <= 1'b0;
            gap_cnt <= '0;
         end else if (!bus.o_cpu_req && gap_cnt != GAP_LAST)
            gap_cnt <= gap_cnt + 16'd1;
         if (ack && (state == WPARAM || state == RRESP)) idx <= idx + 2'd1;
         if (ack && state == RRESP) cmd_resp[32*idx +: 32] <= bus.i_cpu_rdata;
         if (ack && state == POLL) begin
            if (status_ok) cmd_result <= bus.i_cpu_rdata[15:0];
            else begin
               poll_cnt <= poll_cnt + 16'd1;
               if (poll_last) begin
                  cmd_result <= 16'hFFFF;
                  cmd_timeout <= 1'b1;
               end
            end
         end
      end
endmodule

// File: tb/tb_target_cmd_seq.sv
// tb_target_cmd_seq: directed checks of the command sequencer against a scripted bus target
module tb_target_cmd_seq;
   logic clk = 1'b0, reset = 1'b1, cmd_start = 1'b0;
   logic [15:0] cmd_code = '0;
   logic [127:0] cmd_param = '0;
   logic cmd_busy, cmd_done, cmd_timeout;
   logic [15:0] cmd_result;
   logic [127:0] cmd_resp;
   logic rsp_ack = 1'b0, stale_ack = 1'b0;
   logic [31:0] rsp_rdata = '0;
   int checks = 0, failures = 0;
   int ack_delay = 1, ok_at = 0, n_tx = 0, stab_err = 0, done_cnt = 0;
   bit hold_cmd = 1'b0;
   logic [15:0] stat_lo = '0;
   logic [31:0] resp_w [4];
   logic [31:0] log_addr [256], log_wdata [256];
   logic [3:0] log_wstrb [256];
   int log_hi [256], log_gap [256];
   int wait_cnt = 0, low_run = 0, cur_gap = 0, polls = 0;
   logic [31:0] cap_a = '0, cap_d = '0;
   logic [3:0] cap_s = '0;
   logic [127:0] last_resp = '0;
   target_cmd_seq_if bus ();
   assign bus.i_cpu_ack_pulse = rsp_ack | stale_ack;
   assign bus.i_cpu_rdata = rsp_rdata;
   target_cmd_seq #(.GAP_CYCLES(8), .POLL_LIMIT(3)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_code(cmd_code), .cmd_param(cmd_param),
      .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_result(cmd_result), .cmd_resp(cmd_resp),
      .cmd_timeout(cmd_timeout), .bus(bus)
   );
   always #5 clk = ~clk;
   // bus target: acks after ack_delay high cycles, logs each transaction with its preceding low gap
   initial begin
      forever begin
         @(negedge clk);
         rsp_ack = 1'b0;
         if (cmd_done) done_cnt++;
         if (reset) low_run = 0;
         if (!bus.o_cpu_req) begin
            wait_cnt = 0;
            if (!reset) low_run++;
         end else begin
            if (wait_cnt == 0) begin
               cur_gap = low_run;
               low_run = 0;
               cap_a = bus.o_cpu_addr;
               cap_d = bus.o_cpu_wdata;
               cap_s = bus.o_cpu_wstrb;
            end else if (bus.o_cpu_addr !== cap_a || bus.o_cpu_wdata !== cap_d || bus.o_cpu_wstrb !== cap_s)
               stab_err++;
            wait_cnt++;
            if (wait_cnt == ack_delay && !(hold_cmd && cap_a == 0 && cap_s == 4'hF)) begin
               rsp_ack = 1'b1;
               rsp_rdata = 32'h0;
               if (cap_a == 0 && cap_s == 4'hF) polls = 0;
               if (cap_a == 0 && cap_s == 4'h0) begin
                  polls++;
                  rsp_rdata = (polls == ok_at) ? {16'h6F6B, stat_lo} : 32'h1000 + 32'(polls);
               end
               if (cap_a >= 32'h40 && cap_a <= 32'h4C) rsp_rdata = resp_w[cap_a[3:2]];
               if (n_tx < 256) begin
                  log_addr[n_tx] = cap_a;
                  log_wdata[n_tx] = cap_d;
                  log_wstrb[n_tx] = cap_s;
                  log_hi[n_tx] = wait_cnt;
                  log_gap[n_tx] = cur_gap;
               end
               n_tx++;
            end
         end
      end
   end
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_done();
      int n = 0;
      while (!cmd_done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", cmd_done, 1);
      chk("busy_low_at_done", cmd_busy, 0);
   endtask
   task automatic run_cmd(input logic [15:0] code, input logic [127:0] prm, input int okp, input int dly, input bit poke);
      int base, d0, exp_n, n, j;
      logic [31:0] ea;
      logic [127:0] exp_resp;
      ack_delay = dly;
      ok_at = okp;
      stat_lo = code - 16'h0140;
      for (int k = 0; k < 4; k++) resp_w[k] = {code, 16'hA + 16'(k)};
      exp_resp = okp == 0 ? last_resp : {resp_w[3], resp_w[2], resp_w[1], resp_w[0]};
      base = n_tx;
      d0 = done_cnt;
      @(negedge clk);
      cmd_code = code;
      cmd_param = prm;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      cmd_code = 16'hDEAD;
      cmd_param = '1;
      chk("busy_after_start", cmd_busy, 1);
      chk("timeout_cleared", cmd_timeout, 0);
      if (poke) begin
         n = 0;
         while (!(bus.o_cpu_req && bus.o_cpu_addr == 0 && bus.o_cpu_wstrb == 0) && n < 2000) begin
            @(negedge clk);
            n++;
         end
         chk("poke_reached_poll", bus.o_cpu_req, 1);
         cmd_code = 16'h0BAD;
         cmd_param = {4{32'hBAD}};
         cmd_start = 1'b1;
         @(negedge clk);
         cmd_start = 1'b0;
      end
      wait_done();
      exp_n = okp == 0 ? 8 : 9 + okp;
      chk("tx_count", 128'(n_tx - base), 128'(exp_n));
      for (int i = 0; i < exp_n; i++) begin
         j = base + i;
         ea = i < 4 ? 32'h20 + 32'(4 * i) : i < 5 + (okp == 0 ? 3 : okp) ? 32'h0 : 32'h40 + 32'(4 * (i - 5 - okp));
         chk($sformatf("addr[%0d]", i), log_addr[j], ea);
         chk($sformatf("wstrb[%0d]", i), log_wstrb[j], i < 5 ? 4'hF : 4'h0);
         if (i < 5) chk($sformatf("wdata[%0d]", i), log_wdata[j], i < 4 ? prm[32*i +: 32] : {16'h636D, code});
         chk($sformatf("req_high[%0d]", i), 128'(log_hi[j]), 128'(dly));
         if (i > 0) chk($sformatf("gap[%0d]", i), 128'(log_gap[j]), 128'd8);
      end
      chk("result", cmd_result, okp == 0 ? 16'hFFFF : stat_lo);
      chk("timeout", cmd_timeout, okp == 0);
      chk("resp", cmd_resp, exp_resp);
      last_resp = exp_resp;
      repeat (3) @(negedge clk);
      chk("done_pulses", 128'(done_cnt - d0), 128'd1);
      chk("busy_idle", cmd_busy, 0);
      chk("stable_during_req", 128'(stab_err), 128'd0);
   endtask
   initial begin
      int base0, n, t0, d0;
      repeat (3) @(negedge clk);
      chk("rst_req", bus.o_cpu_req, 0);
      chk("rst_busy", cmd_busy, 0);
      chk("rst_done", cmd_done, 0);
      chk("rst_timeout", cmd_timeout, 0);
      chk("rst_addr", bus.o_cpu_addr, 0);
      chk("rst_wdata", bus.o_cpu_wdata, 0);
      chk("rst_wstrb", bus.o_cpu_wstrb, 0);
      chk("rst_result", cmd_result, 0);
      chk("rst_resp", cmd_resp, 0);
      reset = 1'b0;
      base0 = n_tx;
      run_cmd(16'h0140, {32'd4, 32'd3, 32'd2, 32'd1}, 2, 1, 1'b0);
      // start lands one cycle after release; req may rise only at the 8th edge after release
      chk("post_reset_gap", 128'(log_gap[base0]), 128'd7);
      run_cmd(16'h0222, {32'd8, 32'd7, 32'd6, 32'd5}, 1, 5, 1'b0);
      run_cmd(16'h0333, {4{32'h33}}, 0, 1, 1'b0);
      run_cmd(16'h0444, {32'h44, 32'h43, 32'h42, 32'h41}, 2, 1, 1'b1);
      run_cmd(16'h0555, {32'h55, 32'h54, 32'h53, 32'h52}, 2, 1, 1'b0);
      hold_cmd = 1'b1;
      ack_delay = 1;
      @(negedge clk);
      cmd_code = 16'h0300;
      cmd_param = {4{32'h30}};
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      n = 0;
      while (!(bus.o_cpu_req && bus.o_cpu_addr == 0 && bus.o_cpu_wstrb == 4'hF) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("wcmd_req_high", bus.o_cpu_req, 1);
      repeat (2) @(negedge clk);
      t0 = n_tx;
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      chk("midrst_req", bus.o_cpu_req, 0);
      chk("midrst_busy", cmd_busy, 0);
      chk("midrst_addr", bus.o_cpu_addr, 0);
      chk("midrst_wstrb", bus.o_cpu_wstrb, 0);
      chk("midrst_result", cmd_result, 0);
      chk("midrst_resp", cmd_resp, 0);
      @(negedge clk);
      reset = 1'b0;
      hold_cmd = 1'b0;
      @(negedge clk);
      stale_ack = 1'b1;
      @(negedge clk);
      stale_ack = 1'b0;
      repeat (12) @(negedge clk);
      chk("stale_req", bus.o_cpu_req, 0);
      chk("stale_busy", cmd_busy, 0);
      chk("stale_tx", 128'(n_tx - t0), 128'd0);
      chk("stale_done", 128'(done_cnt - d0), 128'd0);
      chk("stale_result", cmd_result, 0);
      last_resp = '0;
      run_cmd(16'h0140, {32'd4, 32'd3, 32'd2, 32'd1}, 2, 1, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
